// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller:
// state encoding and nibble width.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial controller around an external 4-bit full adder.
// Operands arrive through in_valid/in_ready.
// One nibble is fed to the adder per cycle, LSB first.
// The Cout of each nibble is registered and becomes the Cin of the next.
// The wide result is returned through out_valid/out_ready.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_a, in_b, in_cin   : operand pair
//   add_a, add_b, add_cin, add_sum, add_cout: 4-bit adder link
//   out_valid/out_ready, out_sum, out_cout, out_ovf : result
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
  input  logic                          in_cin,
  output logic [NIBBLE_W-1:0]           add_a,
  output logic [NIBBLE_W-1:0]           add_b,
  output logic                          add_cin,
  input  logic [NIBBLE_W-1:0]           add_sum,
  input  logic                          add_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   out_sum,
  output logic                          out_cout,
  output logic                          out_ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;

  logic            last;
  logic            in_add;
  logic            in_done;

  assign last    = (idx == IW'(NIBBLES - 1));
  assign in_add  = (state == ADD);
  assign in_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            carry   <= in_cin;
            idx     <= '0;
            sum_reg <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= add_sum;
          carry <= add_cout;
          if (last) begin
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes decode straight from the state register, so
  // in_ready and out_valid can never be high together.
  assign in_ready  = (state == IDLE);
  assign out_valid = in_done;

  // Adder is fed only while ADD; otherwise it sees zeros.
  assign add_a   = in_add ? a_reg[idx*NIBBLE_W +: NIBBLE_W] : '0;
  assign add_b   = in_add ? b_reg[idx*NIBBLE_W +: NIBBLE_W] : '0;
  assign add_cin = in_add & carry;

  // Result is exposed only while DONE and is held from registers,
  // so it stays stable under backpressure.
  assign out_sum  = in_done ? sum_reg : '0;
  assign out_cout = in_done & carry;
  assign out_ovf  = in_done
                  & (a_reg[W-1] == b_reg[W-1])
                  & (sum_reg[W-1] != a_reg[W-1]);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl.
// The external 4-bit adder is modelled here; results are checked against wide arithmetic.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int tests = 0;
  int fails = 0;

  logic [3:0] cap_a [N];
  logic [3:0] cap_b [N];
  logic       cap_cin [N];
  logic       cap_ov;
  logic       done_ok;

  always #5 clk = ~clk;

  logic [4:0] fa;
  assign fa       = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum  = fa[3:0];
  assign add_cout = fa[4];

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  function automatic logic [W:0] ref_sum(logic [W-1:0] a, logic [W-1:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(logic [W-1:0] a, logic [W-1:0] b, logic c);
    logic [W:0] s;
    s = ref_sum(a, b, c);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Carry into nibble i = carry out of the low 4*i bits.
  function automatic logic ref_cin(logic [W-1:0] a, logic [W-1:0] b, logic c, int i);
    logic [W:0] m;
    logic [W:0] p;
    if (i == 0) return c;
    m = ({{W{1'b0}}, 1'b1} << (4 * i)) - 1'b1;
    p = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
    return p[4*i];
  endfunction

  function automatic logic [3:0] ref_nib(logic [W-1:0] v, int i);
    logic [W-1:0] t;
    t = v >> (4 * i);
    return t[3:0];
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_cin = 1'($urandom);
  endtask

  task automatic capture();
    cap_ov = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cap_a[i] = add_a;
      cap_b[i] = add_b;
      cap_cin[i] = add_cin;
      if (out_valid) cap_ov = 1'b1;
    end
    @(negedge clk);
    done_ok = out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    end
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests++; if (out_sum !== '0) begin fails++; $display("FAIL rst_out_sum: got %h want 0", out_sum); end
    tests++; if ({add_a, add_b, add_cin} !== 9'd0) begin fails++; $display("FAIL rst_add: got %h %h %b want 0", add_a, add_b, add_cin); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL post_rst_idle: got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    tests++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin fails++; $display("FAIL post_rst_flags: got cout=%b ovf=%b want 0 0", out_cout, out_ovf); end
  endtask

  task automatic test_basic();
    logic [3:0] seq [N];
    seq[0] = 4'h4; seq[1] = 4'h3; seq[2] = 4'h2; seq[3] = 4'h1;
    accept(16'h1234, 16'h0FCD, 1'b0);
    capture();
    tests++; if (done_ok !== 1'b1 || cap_ov !== 1'b0) begin fails++; $display("FAIL basic_latency: got done=%b early=%b want 1 0", done_ok, cap_ov); end
    for (int i = 0; i < N; i++) begin
      tests++; if (cap_a[i] !== seq[i]) begin fails++; $display("FAIL basic_add_a[%0d]: got %h want %h", i, cap_a[i], seq[i]); end
      tests++; if (cap_b[i] !== ref_nib(16'h0FCD, i)) begin fails++; $display("FAIL basic_add_b[%0d]: got %h want %h", i, cap_b[i], ref_nib(16'h0FCD, i)); end
    end
    tests++; if (out_sum !== 16'h2201) begin fails++; $display("FAIL basic_sum: got %h want 2201", out_sum); end
    tests++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin fails++; $display("FAIL basic_flags: got cout=%b ovf=%b want 0 0", out_cout, out_ovf); end
    release_out();
  endtask

  task automatic test_carry_chain();
    accept(16'hFFFF, 16'h0000, 1'b1);
    capture();
    for (int i = 0; i < N; i++) begin
      tests++; if (cap_cin[i] !== 1'b1) begin fails++; $display("FAIL chain_cin[%0d]: got %b want 1", i, cap_cin[i]); end
    end
    tests++; if (out_sum !== 16'h0000) begin fails++; $display("FAIL chain_sum: got %h want 0000", out_sum); end
    tests++; if (out_cout !== 1'b1 || out_ovf !== 1'b0) begin fails++; $display("FAIL chain_flags: got cout=%b ovf=%b want 1 0", out_cout, out_ovf); end
    release_out();
  endtask

  task automatic test_overflow();
    accept(16'h7FFF, 16'h0001, 1'b0);
    capture();
    tests++; if (out_sum !== 16'h8000) begin fails++; $display("FAIL ovf1_sum: got %h want 8000", out_sum); end
    tests++; if (out_cout !== 1'b0 || out_ovf !== 1'b1) begin fails++; $display("FAIL ovf1_flags: got cout=%b ovf=%b want 0 1", out_cout, out_ovf); end
    release_out();
    accept(16'h8000, 16'h8000, 1'b0);
    capture();
    tests++; if (out_sum !== 16'h0000) begin fails++; $display("FAIL ovf2_sum: got %h want 0000", out_sum); end
    tests++; if (out_cout !== 1'b1 || out_ovf !== 1'b1) begin fails++; $display("FAIL ovf2_flags: got cout=%b ovf=%b want 1 1", out_cout, out_ovf); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] s;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    s = ref_sum(a, b, c);
    accept(a, b, c);
    capture();
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_a = W'($urandom);
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hs[%0d]: got valid=%b ready=%b want 1 0", i, out_valid, in_ready); end
      tests++; if (out_sum !== s[W-1:0] || out_cout !== s[W] || out_ovf !== ref_ovf(a, b, c)) begin fails++; $display("FAIL bp_hold[%0d]: got %h %b %b want %h %b %b", i, out_sum, out_cout, out_ovf, s[W-1:0], s[W], ref_ovf(a, b, c)); end
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    accept(16'h5678, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_hs: got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    tests++; if ({add_a, add_b, add_cin} !== 9'd0 || out_sum !== '0) begin fails++; $display("FAIL mid_rst_out: got %h %h %b %h want 0", add_a, add_b, add_cin, out_sum); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_hold: got valid=%b want 0", out_valid); end
    rst = 1'b0;
    accept(16'h0001, 16'h0001, 1'b0);
    capture();
    tests++; if (done_ok !== 1'b1 || out_sum !== 16'h0002) begin fails++; $display("FAIL mid_rst_next: got valid=%b sum=%h want 1 0002", done_ok, out_sum); end
    release_out();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] s;
    int d;
    for (int t = 0; t < 40; t++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      s = ref_sum(a, b, c);
      accept(a, b, c);
      capture();
      tests++; if (done_ok !== 1'b1 || cap_ov !== 1'b0) begin fails++; $display("FAIL rnd_latency[%0d]: got done=%b early=%b want 1 0", t, done_ok, cap_ov); end
      for (int i = 0; i < N; i++) begin
        tests++; if (cap_a[i] !== ref_nib(a, i) || cap_cin[i] !== ref_cin(a, b, c, i)) begin fails++; $display("FAIL rnd_nib[%0d][%0d]: got %h %b want %h %b", t, i, cap_a[i], cap_cin[i], ref_nib(a, i), ref_cin(a, b, c, i)); end
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL rnd_hs[%0d]: got valid=%b ready=%b want 1 0", t, out_valid, in_ready); end
      tests++; if (out_sum !== s[W-1:0] || out_cout !== s[W]) begin fails++; $display("FAIL rnd_sum[%0d]: got %h %b want %h %b", t, out_sum, out_cout, s[W-1:0], s[W]); end
      tests++; if (out_ovf !== ref_ovf(a, b, c)) begin fails++; $display("FAIL rnd_ovf[%0d]: got %b want %b", t, out_ovf, ref_ovf(a, b, c)); end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [W:0] s;
    int acc [3];
    int n;
    a = W'($urandom); b = W'($urandom);
    s = ref_sum(a, b, 1'b0);
    n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      if (in_ready) begin
        acc[n] = cyc;
        n++;
      end
      if (out_valid) begin
        tests++; if (out_sum !== s[W-1:0]) begin fails++; $display("FAIL b2b_sum: got %h want %h", out_sum, s[W-1:0]); end
      end
      tests++; if (in_ready && out_valid) begin fails++; $display("FAIL b2b_excl: got ready=1 valid=1 want not both"); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", n); end
    else begin
      tests++; if (acc[1] - acc[0] !== N + 2) begin fails++; $display("FAIL b2b_gap1: got %0d want %0d", acc[1] - acc[0], N + 2); end
      tests++; if (acc[2] - acc[1] !== N + 2) begin fails++; $display("FAIL b2b_gap2: got %0d want %0d", acc[2] - acc[1], N + 2); end
    end
    repeat (2 * (N + 2)) @(negedge clk);
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain: got ready=%b want 1", in_ready); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Upstream/downstream controller for the team's combinational 4-bit ripple-carry full adder.
- Accepts wide operands through a valid/ready handshake.
- Feeds the 4-bit adder one nibble per cycle, LSB nibble first, and feeds the registered carry back into Cin on the next nibble.
- Collects each nibble's Sum into a result register, then presents the wide result and Cout through an output valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  initial carry-in.
- add_a  output  4  A nibble to the 4-bit adder.
- add_b  output  4  B nibble to the 4-bit adder.
- add_cin  output  1  carry to the 4-bit adder.
- add_sum  input  4  Sum returned by the adder, combinational in the same cycle.
- add_cout  input  1  Cout returned by the adder.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W  full sum.
- out_cout  output  1  final carry-out.
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, idx=0, carry=0, a_reg=b_reg=sum_reg=0.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - add_a=add_b=0, add_cin=0.
  - Reset asserted mid-operation discards all work; no partial output is ever emitted.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: a_reg<=in_a, b_reg<=in_b, carry<=in_cin, idx<=0, sum_reg<=0, go to ADD.
- ADD:
  - in_ready=0.
  - add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
  - Each edge: sum_reg[4*idx+:4]<=add_sum, carry<=add_cout.
  - If idx==NIBBLES-1, go to DONE; otherwise idx<=idx+1.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum=sum_reg, out_cout=carry.
  - out_ovf=(a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]).
  - On out_ready at an edge, go to IDLE.
  - Outputs stay stable while out_valid=1 and out_ready=0 (backpressure holds indefinitely).
- Outside ADD: add_a, add_b, add_cin are driven 0.
- Latency:
  - Operands accepted at edge k.
  - ADD occupies edges k+1..k+NIBBLES.
  - out_valid is high from just after edge k+NIBBLES.
  - Minimum issue interval is NIBBLES+2 cycles.
  - No overlap: in_ready=0 in ADD and DONE, so in_valid is ignored there.
- out_valid and in_ready are never high together.
- idx width = clog2(NIBBLES), minimum 1 bit.
- idx wrap-around never occurs; it is reset to 0 on every accept.
- NIBBLES=1 degenerates to a single ADD cycle.
- Input values are sampled only at the accept edge; later changes are ignored.

Decomposition:
- Shared package adder_pkg holds:
  - state encoding: IDLE=2'd0, ADD=2'd1, DONE=2'd2.
  - NIBBLE_W=4.
- Sub-modules: none. The 4-bit full adder stays external and is connected via the add_* ports by the parent wrapper.
- Wrapper name: nibble_serial_adder_top. It instantiates this block plus the existing 4-bit full adder.

Test Plan:
- Reset check:
  - Stimulus: assert rst for 2 cycles with random inputs.
  - Required response: in_ready=1, out_valid=0, out_sum=0, add_* = 0.
- Basic add, NIBBLES=4:
  - Stimulus: in_a=16'h1234, in_b=16'h0FCD, in_cin=0.
  - Required response: out_valid after 4 ADD cycles; out_sum=16'h2201, out_cout=0, out_ovf=0.
  - add_a sequence: 4, 3, 2, 1.
- Full carry chain:
  - Stimulus: in_a=16'hFFFF, in_b=16'h0000, in_cin=1.
  - Required response: out_sum=16'h0000, out_cout=1, out_ovf=0.
  - add_cin per nibble: 1, 1, 1, 1.
- Signed overflow:
  - Stimulus: in_a=16'h7FFF, in_b=16'h0001.
  - Required response: out_sum=16'h8000, out_cout=0, out_ovf=1.
  - Second stimulus: 16'h8000+16'h8000 gives out_sum=0, out_cout=1, out_ovf=1.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 10 cycles while toggling in_valid and changing in_a.
  - Required response: outputs stable, in_ready=0, no new accept.
  - Release out_ready: return to IDLE in 1 cycle with in_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst during the second ADD cycle.
  - Required response: immediate IDLE and all outputs 0.
  - Next transaction 16'h0001+16'h0001 gives out_sum=16'h0002.
